// File: rtl/wbm_rr_arbiter_pkg.sv
// Shared definitions for the Wishbone classic round-robin arbiter:
// FSM state encoding, requester index constants and sizing helpers.
package wbm_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Requester slots in the packed request buses
  localparam int unsigned REQ_BMC   = 0;
  localparam int unsigned REQ_SPIC  = 1;
  localparam int unsigned REQ_PCIEC = 2;

  // Timeout counter width; covers TIMEOUT values up to 65535
  localparam int unsigned TMO_CNT_W = 16;

  // Width of an index into n requesters (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbm_rr_arbiter_rr_priority_sel.sv
// Round-robin priority selector: picks the first asserted request searching
// upward (with wrap) from the slot after the last grant. Purely combinational.
module rr_priority_sel
  import wbm_rr_arbiter_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o
);

  // Scan offsets 1..N from the last grant; first hit wins
  always_comb begin
    logic        found;
    int unsigned last_u;
    int unsigned cand;
    gnt_o  = '0;
    found  = 1'b0;
    last_u = 32'(last_i);
    cand   = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (last_u + off) % N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (i == cand) && req_i[i]) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wbm_rr_arbiter.sv
// Wishbone classic arbiter: several requesters share one slave port.
// Round-robin grant on idle, grant held for the whole cycle (cyc high),
// per-transfer timeout that errors the owner and parks the bus in ABORT.
module wbm_rr_arbiter
  import wbm_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [NUM_MASTERS-1:0]                m_rty_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_rty_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = idx_width(NUM_MASTERS);
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [IDX_W-1:0]       last_q;
  logic [TMO_CNT_W-1:0]   cnt_q;
  logic [TMO_CNT_W-1:0]   cnt_d;

  // Unpacked views of the packed requester buses
  logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
  logic [SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign adr_arr[g] = m_adr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[g] = m_dat_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign sel_arr[g] = m_sel_i[g*SEL_WIDTH +: SEL_WIDTH];
  end

  // Granted requester's signals and index
  logic                  g_cyc;
  logic                  g_stb;
  logic                  g_we;
  logic [ADDR_WIDTH-1:0] g_adr;
  logic [DATA_WIDTH-1:0] g_dat;
  logic [SEL_WIDTH-1:0]  g_sel;
  logic [IDX_W-1:0]      gnt_idx;

  logic busy;
  logic term_any;
  logic tmo_hit;

  rr_priority_sel #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (grant_d)
  );

  // Select the owner's request signals from the one-hot grant
  always_comb begin
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    g_we    = 1'b0;
    g_adr   = '0;
    g_dat   = '0;
    g_sel   = '0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        g_cyc   = m_cyc_i[i];
        g_stb   = m_stb_i[i];
        g_we    = m_we_i[i];
        g_adr   = adr_arr[i];
        g_dat   = dat_arr[i];
        g_sel   = sel_arr[i];
        gnt_idx = IDX_W'(i);
      end
    end
  end

  // Timeout detection; a real termination in the same cycle takes priority.
  // The bus drops on the cycle after the error pulse, when ABORT is entered.
  always_comb begin
    busy     = (state_q == ST_BUSY);
    term_any = s_ack_i | s_err_i | s_rty_i;
    tmo_hit  = busy && g_cyc && (cnt_q == TMO_LIMIT) && !term_any;
    if (term_any) begin
      cnt_d = '0;
    end else if (g_stb && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shared-bus drive and termination routing to the owner only
  always_comb begin
    s_cyc_o = busy ? g_cyc : 1'b0;
    s_stb_o = busy ? g_stb : 1'b0;
    s_we_o  = busy ? g_we  : 1'b0;
    s_adr_o = busy ? g_adr : '0;
    s_dat_o = busy ? g_dat : '0;
    s_sel_o = busy ? g_sel : '0;
    m_ack_o = busy ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
    m_err_o = busy ? (grant_q & {NUM_MASTERS{s_err_i | tmo_hit}}) : '0;
    m_rty_o = busy ? (grant_q & {NUM_MASTERS{s_rty_i}}) : '0;
    m_dat_o = s_dat_i;
    grant_o = grant_q;
  end

  // Arbitration FSM: grant, hold for the cycle, timeout abort, release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            grant_q <= grant_d;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!g_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= gnt_idx;
            cnt_q   <= '0;
          end else if (tmo_hit) begin
            state_q <= ST_ABORT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_ABORT: begin
          if (!g_cyc) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= gnt_idx;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// Directed self-checking bench for wbm_rr_arbiter (3 requesters, TIMEOUT=8).
module tb_wbm_rr_arbiter;
  import wbm_rr_arbiter_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic              clk;
  logic              rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*SW-1:0]  m_sel;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err, s_rty;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [NM-1:0] G_BMC   = 3'b001 << REQ_BMC;
  localparam logic [NM-1:0] G_SPIC  = 3'b001 << REQ_SPIC;
  localparam logic [NM-1:0] G_PCIEC = 3'b001 << REQ_PCIEC;

  wbm_rr_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT     (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .s_rty_i (s_rty),
    .grant_o (grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to just after the next active edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL reset_grant got=%b exp=000", grant_o); end
    n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=000", {s_cyc_o, s_stb_o, s_we_o}); end
    n_checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 9'b0) begin n_fail++; $display("FAIL reset_term got=%b exp=0", {m_ack_o, m_err_o, m_rty_o}); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL reset_release_grant got=%b exp=000", grant_o); end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp_g [4];
    logic [AW-1:0] exp_a [4];
    exp_g = '{G_BMC, G_SPIC, G_PCIEC, G_BMC};
    exp_a = '{22'h000100, 22'h000200, 22'h000300, 22'h000100};
    next_cycle();
    m_cyc = 3'b111; m_stb = 3'b111; m_we = 3'b000;
    m_adr = {22'h000300, 22'h000200, 22'h000100};
    @(negedge clk);
    n_checks++; if (s_cyc_o !== 1'b0 || s_adr_o !== '0) begin n_fail++; $display("FAIL rr_idle_bus cyc=%b adr=%h exp cyc=0 adr=0", s_cyc_o, s_adr_o); end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (grant_o !== exp_g[k]) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, grant_o, exp_g[k]); end
      n_checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== exp_a[k]) begin n_fail++; $display("FAIL rr_bus[%0d] cyc=%b adr=%h exp cyc=1 adr=%h", k, s_cyc_o, s_adr_o, exp_a[k]); end
      next_cycle();
      s_ack = 1'b1;
      m_cyc = 3'b111 & ~exp_g[k];
      @(negedge clk);
      n_checks++; if (m_ack_o !== exp_g[k] || m_err_o !== 3'b000) begin n_fail++; $display("FAIL rr_ack[%0d] ack=%b err=%b exp ack=%b err=000", k, m_ack_o, m_err_o, exp_g[k]); end
      next_cycle();
      s_ack = 1'b0;
      m_cyc = (k == 3) ? 3'b000 : 3'b111;
      @(negedge clk);
      n_checks++; if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d] grant=%b cyc=%b exp 000/0", k, grant_o, s_cyc_o); end
    end
    m_stb = '0;
  endtask

  task automatic test_read();
    next_cycle();
    m_cyc = G_SPIC; m_stb = G_SPIC; m_we = 3'b000;
    m_adr[AW +: AW] = 22'h000010;
    m_sel = {4'hC, 4'h3, 4'hF};
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== G_SPIC) begin n_fail++; $display("FAIL rd_grant got=%b exp=%b", grant_o, G_SPIC); end
    n_checks++; if (s_adr_o !== 22'h000010 || s_we_o !== 1'b0 || s_sel_o !== 4'h3) begin n_fail++; $display("FAIL rd_bus adr=%h we=%b sel=%h exp 000010/0/3", s_adr_o, s_we_o, s_sel_o); end
    next_cycle();
    s_rty = 1'b1;
    @(negedge clk);
    n_checks++; if (m_rty_o !== G_SPIC || m_ack_o !== 3'b000) begin n_fail++; $display("FAIL rd_rty rty=%b ack=%b exp 010/000", m_rty_o, m_ack_o); end
    next_cycle();
    s_rty = 1'b0; s_ack = 1'b1; s_dat = 32'hDEADBEEF;
    m_cyc = '0; m_stb = '0;
    @(negedge clk);
    n_checks++; if (m_ack_o !== G_SPIC) begin n_fail++; $display("FAIL rd_ack got=%b exp=%b", m_ack_o, G_SPIC); end
    n_checks++; if (m_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", m_dat_o); end
    next_cycle();
    s_ack = 1'b0; s_dat = '0;
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000 || m_ack_o !== 3'b000) begin n_fail++; $display("FAIL rd_release grant=%b ack=%b exp 000/000", grant_o, m_ack_o); end
  endtask

  task automatic test_timeout();
    next_cycle();
    m_cyc = G_BMC; m_stb = G_BMC; m_we = G_BMC;
    m_dat[DW-1:0] = 32'h12345678;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (m_err_o !== 3'b000 || s_cyc_o !== 1'b1) begin n_fail++; $display("FAIL tmo_wait[%0d] err=%b cyc=%b exp 000/1", c, m_err_o, s_cyc_o); end
      if (c == 1) begin
        n_checks++; if (s_dat_o !== 32'h12345678 || s_we_o !== 1'b1) begin n_fail++; $display("FAIL tmo_wdata dat=%h we=%b exp 12345678/1", s_dat_o, s_we_o); end
      end
    end
    next_cycle();
    @(negedge clk);
    n_checks++; if (m_err_o !== G_BMC) begin n_fail++; $display("FAIL tmo_err got=%b exp=%b", m_err_o, G_BMC); end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000 || m_err_o !== 3'b000 || grant_o !== G_BMC) begin
        n_fail++; $display("FAIL tmo_abort[%0d] ctrl=%b err=%b grant=%b exp 000/000/%b", c, {s_cyc_o, s_stb_o, s_we_o}, m_err_o, grant_o, G_BMC);
      end
    end
    next_cycle();
    m_cyc = '0; m_stb = '0; m_we = '0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL tmo_release got=%b exp=000", grant_o); end
  endtask

  task automatic test_ack_on_timeout();
    next_cycle();
    m_cyc = G_BMC; m_stb = G_BMC; m_we = 3'b000;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
    s_ack = 1'b1;
    m_cyc = '0; m_stb = '0;
    @(negedge clk);
    n_checks++; if (m_ack_o !== G_BMC || m_err_o !== 3'b000) begin n_fail++; $display("FAIL tmo_ack_wins ack=%b err=%b exp %b/000", m_ack_o, m_err_o, G_BMC); end
    next_cycle();
    s_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000 || m_err_o !== 3'b000) begin n_fail++; $display("FAIL tmo_ack_release grant=%b err=%b exp 000/000", grant_o, m_err_o); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    m_cyc = G_PCIEC | G_BMC; m_stb = G_PCIEC | G_BMC; m_we = 3'b000;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      next_cycle();
      m_stb = G_PCIEC | G_BMC; s_ack = 1'b1;
      @(negedge clk);
      n_checks++; if (grant_o !== G_PCIEC || m_ack_o !== G_PCIEC || s_stb_o !== 1'b1) begin
        n_fail++; $display("FAIL blk_word[%0d] grant=%b ack=%b stb=%b exp %b/%b/1", w, grant_o, m_ack_o, s_stb_o, G_PCIEC, G_PCIEC);
      end
      next_cycle();
      s_ack = 1'b0; m_stb = G_BMC;
      if (w == 3) m_cyc = G_BMC;
      @(negedge clk);
      n_checks++; if (grant_o !== G_PCIEC || s_stb_o !== 1'b0 || m_ack_o !== 3'b000) begin
        n_fail++; $display("FAIL blk_gap[%0d] grant=%b stb=%b ack=%b exp %b/0/000", w, grant_o, s_stb_o, m_ack_o, G_PCIEC);
      end
    end
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000) begin n_fail++; $display("FAIL blk_idle got=%b exp=000", grant_o); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== G_BMC) begin n_fail++; $display("FAIL blk_next_grant got=%b exp=%b", grant_o, G_BMC); end
    next_cycle();
    m_cyc = '0; m_stb = '0;
    next_cycle();
  endtask

  task automatic test_reset_mid_write();
    next_cycle();
    m_cyc = G_SPIC; m_stb = G_SPIC; m_we = G_SPIC;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== G_SPIC || s_we_o !== 1'b1) begin n_fail++; $display("FAIL rstw_grant grant=%b we=%b exp %b/1", grant_o, s_we_o, G_SPIC); end
    next_cycle();
    rst = 1'b1; s_ack = 1'b1; s_err = 1'b1;
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000 || {s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin n_fail++; $display("FAIL rstw_ctrl grant=%b ctrl=%b exp 000/000", grant_o, {s_cyc_o, s_stb_o, s_we_o}); end
    n_checks++; if ({m_ack_o, m_err_o, m_rty_o} !== 9'b0) begin n_fail++; $display("FAIL rstw_term got=%b exp=0", {m_ack_o, m_err_o, m_rty_o}); end
    n_checks++; if (s_adr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0) begin n_fail++; $display("FAIL rstw_bus adr=%h dat=%h sel=%h exp 0", s_adr_o, s_dat_o, s_sel_o); end
    next_cycle();
    rst = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    m_cyc = 3'b111; m_stb = 3'b111; m_we = 3'b000;
    @(negedge clk);
    n_checks++; if (grant_o !== 3'b000 || m_ack_o !== 3'b000) begin n_fail++; $display("FAIL rstw_idle grant=%b ack=%b exp 000/000", grant_o, m_ack_o); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (grant_o !== G_BMC) begin n_fail++; $display("FAIL rstw_first_grant got=%b exp=%b", grant_o, G_BMC); end
    next_cycle();
    m_cyc = '0; m_stb = '0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_timeout();
    test_ack_on_timeout();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbm_rr_arbiter.md
WBM_RR_ARBITER -- requirements
Module: wbm_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of Wishbone classic requesters (bmc, spic, pciec order).
REQ-002 SHALL have parameter ADDR_WIDTH, default 22, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32; select width is DATA_WIDTH/8.
REQ-004 SHALL have parameter TIMEOUT, default 255, cycles without termination before abort (1..65535).
REQ-005 clk_i  in  1  sole clock.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 m_cyc_i  in  NUM_MASTERS  per-requester cycle.
REQ-008 m_stb_i  in  NUM_MASTERS  per-requester strobe.
REQ-009 m_we_i  in  NUM_MASTERS  per-requester write enable.
REQ-010 m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, requester 0 in LSBs.
REQ-011 m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
REQ-012 m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects.
REQ-013 m_dat_o  out  DATA_WIDTH  read data, broadcast to all requesters.
REQ-014 m_ack_o / m_err_o / m_rty_o  out  NUM_MASTERS each  per-requester termination.
REQ-015 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared bus controls.
REQ-016 s_adr_o  out  ADDR_WIDTH;  s_dat_o  out  DATA_WIDTH;  s_sel_o  out  DATA_WIDTH/8.
REQ-017 s_dat_i  in  DATA_WIDTH;  s_ack_i, s_err_i, s_rty_i  in  1 each.
REQ-018 grant_o  out  NUM_MASTERS  one-hot current owner (zero when idle), for debug/status.

Function
REQ-019 SHALL implement states IDLE, BUSY, ABORT.
REQ-020 In IDLE, on any m_cyc_i set, SHALL register a one-hot grant choosing first requester with cyc set searching upward (wrapping) from last_grant+1, then enter BUSY; grant visible on s_cyc_o the following cycle (1-cycle latency).
REQ-021 In BUSY, s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o/s_sel_o SHALL combinationally follow the granted requester's inputs.
REQ-022 In BUSY, s_ack_i/s_err_i/s_rty_i SHALL route combinationally only to the granted requester's m_*_o bit; all other bits 0.
REQ-023 Grant SHALL be held while granted m_cyc_i is high (block transfers uninterrupted); on granted m_cyc_i low, SHALL return to IDLE, update last_grant, drive grant_o 0; next grant earliest one cycle later.
REQ-024 Timeout counter SHALL clear on grant and on any s_ack_i/s_err_i/s_rty_i, increment each BUSY cycle with s_stb_o high and no termination, saturating.
REQ-025 When counter reaches TIMEOUT, SHALL pulse granted m_err_o for exactly one cycle, force s_cyc_o/s_stb_o low, enter ABORT.
REQ-026 In ABORT, s_cyc_o/s_stb_o SHALL stay low and all m_*_o terminations 0 until granted m_cyc_i drops, then IDLE.
REQ-027 Termination arriving in the same cycle as timeout SHALL win: normal termination forwarded, no abort.
REQ-028 Requester dropping cyc in the same cycle as its termination SHALL be legal; arbiter releases per REQ-023.
REQ-029 Outside BUSY, s_cyc_o, s_stb_o, s_we_o SHALL be 0 and s_adr_o/s_dat_o/s_sel_o 0.
REQ-030 m_dat_o SHALL equal s_dat_i at all times.

Reset
REQ-031 rst_i SHALL immediately force state IDLE, grant_o 0, counter 0, all s_cyc/stb/we and m_ack/err/rty outputs 0, last_grant NUM_MASTERS-1 (requester 0 wins first).
REQ-032 Reset mid-transaction SHALL abandon the cycle without any termination pulse.

Structure
REQ-033 State encoding and requester index constants (BMC=0, SPIC=1, PCIEC=2) SHALL live in a shared wishbone package/include.
REQ-034 Round-robin priority selection SHALL be a sub-module rr_priority_sel (request vector + last grant in, one-hot out, combinational).

Verification
REQ-035 Reset then m_cyc_i=3'b111 held, each acked after 2 cycles -> grants 0,1,2,0 in order, each s_cyc_o starting 1 cycle after IDLE.
REQ-036 Requester 1 read adr 0x000010, slave acks with s_dat_i=0xDEADBEEF -> m_ack_o=3'b010 that cycle, m_dat_o=0xDEADBEEF.
REQ-037 TIMEOUT=8, slave never responds -> m_err_o granted bit high exactly 8 cycles after grant, s_cyc_o low next cycle, ABORT held until requester drops cyc.
REQ-038 TIMEOUT=8, s_ack_i on the 8th cycle -> ack forwarded, no err.
REQ-039 Requester 2 4-word block (cyc held, stb toggled) while requester 0 requests -> requester 0 not granted until requester 2 cyc falls.
REQ-040 rst_i asserted mid-write -> all outputs 0 same cycle, no ack/err pulse, first grant after release goes to requester 0.
